// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int SERIAL_SUB_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full-subtractor cell: diff = x - y - bin, with borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor d = a - b, LSB first, start/done handshake.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SERIAL_SUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             diff;
  logic             br_next;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb;
  logic             b_msb;
`endif

  full_subtractor u_fs (
    .x    (a_sr[0]),
    .y    (b_sr[0]),
    .bin  (br),
    .diff (diff),
    .bout (br_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      d     <= '0;
      bout  <= 1'b0;
      br    <= 1'b0;
      cnt   <= '0;
      a_sr  <= '0;
      b_sr  <= '0;
      res   <= '0;
`ifdef SERIAL_SUB_OVF_EN
      ovf   <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            br    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
`ifdef SERIAL_SUB_OVF_EN
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
`endif
          end
        end
        SHIFT: begin
          res  <= {diff, res[WIDTH-1:1]};
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          br   <= br_next;
          cnt  <= cnt + CW'(1);
          // Final bit: publish the completed word directly, diff lands in the MSB.
          if (cnt == LAST) begin
            d     <= {diff, res[WIDTH-1:1]};
            bout  <= br_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
`ifdef SERIAL_SUB_OVF_EN
            ovf   <= (a_msb ^ b_msb) & (diff ^ a_msb);
`endif
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): vector table, corner sequences, random ops.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int errors = 0;
  int checks = 0;
  logic [W-1:0] last_d;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] ed;
    logic         eb;
    logic         eo;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: integer arithmetic on unsigned and signed interpretations.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                       output logic [W-1:0] ed, output logic eb, output logic eo);
    int ud;
    int sd;
    ud = int'(ma) - int'(mb);
    sd = int'($signed(ma)) - int'($signed(mb));
    ed = W'(ud);
    eb = (ud < 0);
    eo = (sd < -(1 << (W - 1))) || (sd > (1 << (W - 1)) - 1);
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic [W-1:0] ed,
                        input logic eb, input logic eo, input bit repulse);
    bit ok_busy;
    bit ok_hold;
    bit extra;
    @(negedge clk);
    start = 1'b1;
    a = ta;
    b = tb_;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    ok_busy = 1'b1;
    ok_hold = 1'b1;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      if (!busy || done) ok_busy = 1'b0;
      if (d !== last_d) ok_hold = 1'b0;
      if (repulse && i == 2) begin
        start = 1'b1;
        a = ~ta;
        b = ~tb_;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("busy_window", 32'(ok_busy), 32'd1);
    check("d_hold_during_shift", 32'(ok_hold), 32'd1);
    @(negedge clk);
    check("done_at_latency", 32'(done), 32'd1);
    check("busy_low_at_done", 32'(busy), 32'd0);
    check("d", 32'(d), 32'(ed));
    check("bout", 32'(bout), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
    check("ovf", 32'(ovf), 32'(eo));
`else
    if (eo === 1'bx) $display("note: undefined overflow expectation");
`endif
    last_d = ed;
    extra = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) extra = 1'b1;
    end
    check("single_done_pulse", 32'(extra), 32'd0);
    check("d_stable_after_done", 32'(d), 32'(ed));
  endtask

  vec_t tbl[8];

  initial begin
    logic [W-1:0] ed;
    logic eb;
    logic eo;
    bit seen;
    int n;
    int t[3];

    tbl[0] = '{a: 8'h0F, b: 8'h05, ed: 8'h0A, eb: 1'b0, eo: 1'b0};
    tbl[1] = '{a: 8'h05, b: 8'h0F, ed: 8'hF6, eb: 1'b1, eo: 1'b0};
    tbl[2] = '{a: 8'h00, b: 8'h01, ed: 8'hFF, eb: 1'b1, eo: 1'b0};
    tbl[3] = '{a: 8'hA5, b: 8'hA5, ed: 8'h00, eb: 1'b0, eo: 1'b0};
    tbl[4] = '{a: 8'h80, b: 8'h01, ed: 8'h7F, eb: 1'b0, eo: 1'b1};
    tbl[5] = '{a: 8'h7F, b: 8'hFF, ed: 8'h80, eb: 1'b1, eo: 1'b1};
    tbl[6] = '{a: 8'h10, b: 8'h08, ed: 8'h08, eb: 1'b0, eo: 1'b0};
    tbl[7] = '{a: 8'hFF, b: 8'h00, ed: 8'hFF, eb: 1'b0, eo: 1'b0};

    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_d", 32'(d), 32'd0);
    check("reset_bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("reset_ovf", 32'(ovf), 32'd0);
`endif
    rst = 1'b0;
    last_d = '0;

    for (int i = 0; i < 8; i++)
      run_op(tbl[i].a, tbl[i].b, tbl[i].ed, tbl[i].eb, tbl[i].eo, 1'b0);

    // start re-pulsed mid-SHIFT with different operands is ignored
    run_op(8'h33, 8'h11, 8'h22, 1'b0, 1'b0, 1'b1);

    // rst and start at the same edge: rst wins
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    a = 8'h44;
    b = 8'h22;
    @(negedge clk);
    check("rst_start_busy", 32'(busy), 32'd0);
    check("rst_start_d", 32'(d), 32'd0);
    rst = 1'b0;
    start = 1'b0;
    last_d = '0;
    seen = 1'b0;
    repeat (W + 3) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    check("rst_start_no_op", 32'(seen), 32'd0);

    // reset three cycles into SHIFT abandons the operation
    @(negedge clk);
    start = 1'b1;
    a = 8'h3C;
    b = 8'h0D;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_d", 32'(d), 32'd0);
    check("midrst_bout", 32'(bout), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (W + 4) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("midrst_no_done", 32'(seen), 32'd0);
    last_d = '0;
    run_op(8'h0F, 8'h05, 8'h0A, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = W'($urandom);
      rb = W'($urandom);
      model(ra, rb, ed, eb, eo);
      run_op(ra, rb, ed, eb, eo, 1'b0);
    end

    // start held high: one operation per W+2 cycles
    @(negedge clk);
    a = 8'hC3;
    b = 8'h5A;
    start = 1'b1;
    n = 0;
    for (int c = 0; c < 60 && n < 3; c++) begin
      @(negedge clk);
      if (done) begin
        t[n] = c;
        n++;
      end
    end
    start = 1'b0;
    check("hold_pulses", 32'(n), 32'd3);
    if (n == 3) begin
      check("hold_gap1", 32'(t[1] - t[0]), 32'(W + 2));
      check("hold_gap2", 32'(t[2] - t[1]), 32'(W + 2));
    end
    repeat (W + 4) @(negedge clk);
    model(8'hC3, 8'h5A, ed, eb, eo);
    check("hold_d", 32'(d), 32'(ed));
    check("hold_bout", 32'(bout), 32'(eb));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial two's-complement subtractor computing d = a − b one bit per clock, LSB first, with a single borrow flip-flop between bit slices. It is the inverse arithmetic counterpart of the full-adder datapath: a one-bit full-subtractor cell plus shift registers and a control FSM. It targets area-constrained datapaths where a WIDTH-bit ripple subtractor is too large, and it is driven by a simple start/done handshake.

## Interface
- WIDTH, 8, operand and result width in bits (≥ 2)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend; captured on the accepted start edge
- b  input  WIDTH  subtrahend; captured on the accepted start edge
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse when the result is valid
- d  output  WIDTH  difference a − b mod 2^WIDTH; held until the next accepted start
- bout  output  1  final borrow; 1 iff a < b unsigned
- ovf  output  1  signed overflow (present only with SERIAL_SUB_OVF_EN)

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 loads a and b into shift registers, clears the borrow register and the bit counter, and moves to SHIFT.
  - start=0 stays in IDLE.
- SHIFT: each cycle, with x = a_sr[0], y = b_sr[0], br = borrow:
  - diff = x ^ y ^ br
  - br_next = (~x & y) | (~(x ^ y) & br)
  - diff shifts into the MSB of the result register; a_sr and b_sr shift right; the counter increments.
  - After the WIDTH-th bit, d is updated from the result register, bout takes br_next, and the FSM moves to DONE.
- DONE: done=1 for exactly one cycle, then the FSM returns to IDLE unconditionally.
- start is ignored in SHIFT and DONE. It is not queued.
- d, bout and ovf change only at the end of SHIFT. They are stable through DONE and IDLE.
- Width rules: all arithmetic is modulo 2^WIDTH. The counter is $clog2(WIDTH+1) bits wide.
- Input a/b changes after the start edge have no effect on the operation in progress.

## Timing
- Reset (rst=1 at a clock edge), effective on the following cycle: state=IDLE, busy=0, done=0, d=0, bout=0, ovf=0, borrow=0, counter=0.
- Reset mid-operation: the result is abandoned, all outputs take their reset values, and no done pulse is produced.
- Start accepted at edge E0:
  - busy=1 from after E0 through edge E0+WIDTH.
  - done=1 in the cycle after edge E0+WIDTH, i.e. latency WIDTH cycles from the accepting edge to done.
  - busy=0 while done=1.
- Minimum spacing between accepted starts: WIDTH+2 cycles. start held high continuously yields one operation per WIDTH+2 cycles.
- rst and start both high at the same edge: rst wins and start is discarded.

## Configuration
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - Port ovf exists.
  - At the end of SHIFT, ovf = (a[MSB] != b[MSB]) & (d[MSB] != a[MSB]), using the captured operand MSBs (held in registers).
  - ovf is valid alongside d and bout, and is reset to 0.
- Undefined: port ovf and its MSB capture registers are absent. All other behaviour is identical.

## Structure
- Shared package serial_sub_pkg holds:
  - state encoding constants IDLE=2'd0, SHIFT=2'd1, DONE=2'd2
  - default width constant SERIAL_SUB_WIDTH=8
- Sub-module full_subtractor: purely combinational one-bit cell.
  - Inputs: x, y, bin.
  - Outputs: diff, bout.
  - It is instantiated once and fed by the shift-register LSBs and the borrow flop.
- The top level owns the FSM, counter, shift registers, borrow flop and output registers.

## Test plan
All scenarios use WIDTH=8.
- a=0x0F, b=0x05, start pulse → busy 8 cycles; done 8 cycles after the start edge; d=0x0A, bout=0.
- a=0x05, b=0x0F → d=0xF6, bout=1.
- a=0x00, b=0x01 → d=0xFF, bout=1. Also a=b=0xA5 → d=0x00, bout=0.
- With SERIAL_SUB_OVF_EN: a=0x80, b=0x01 → d=0x7F, bout=0, ovf=1. Also a=0x7F, b=0xFF → d=0x80, bout=1, ovf=1. Also a=0x10, b=0x08 → ovf=0.
- Start re-pulsed with different a/b during SHIFT → ignored; the original result is delivered and exactly one done pulse occurs.
- rst asserted 3 cycles into SHIFT → next cycle busy=0, d=0, bout=0, no done pulse. A subsequent start with a=0x0F, b=0x05 → d=0x0A.
